// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounce/synchroniser input stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        PEND_HIGH,
        STABLE_HIGH,
        PEND_LOW
    } debounce_state_t;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous bit, async active-high reset.
module sync_chain #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    if (N < 2) begin : g_bad_n
        $error("sync_chain: N must be >= 2");
    end

    logic [N-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/debounce_sync_filter.sv
// Synchronises a raw async input and accepts a new level only after
// STABLE_CYCLES consecutive qualifying ticks; emits one-cycle rise/fall strobes.
module debounce_sync_filter
    import debounce_pkg::*;
#(
    parameter  int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter  int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_sync_filter: STABLE_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam bit               SINGLE   = (STABLE_CYCLES == 1);

    logic            w_a_s;
    debounce_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic            r_level, w_level_nxt;
    logic            r_rise, w_rise_nxt;
    logic            r_fall, w_fall_nxt;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (a_raw),
        .o_q (w_a_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // With a window of one, a stable state accepts directly and never enters a pending state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (tick) begin
            case (r_state)
                STABLE_LOW: begin
                    if (w_a_s) begin
                        if (SINGLE) begin
                            w_state_nxt = STABLE_HIGH;
                            w_level_nxt = 1'b1;
                            w_rise_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = PEND_HIGH;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PEND_HIGH: begin
                    if (!w_a_s) begin
                        w_state_nxt = STABLE_LOW;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_HIGH;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!w_a_s) begin
                        if (SINGLE) begin
                            w_state_nxt = STABLE_LOW;
                            w_level_nxt = 1'b0;
                            w_fall_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = PEND_LOW;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PEND_LOW: begin
                    if (w_a_s) begin
                        w_state_nxt = STABLE_HIGH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE_LOW;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
